reg_file_multiport: RTL and testbench
=====================================

# reg_file_multiport

Parametrised, clocked register file for the single-cycle core: synchronous write, NUM_RD combinational read ports, entry 0 hard-wired to zero, and a hardware clear sequencer that sweeps the array to zero on request. It sits between the decode stage (read addresses) and write-back (write port).

## Interface

- DATA_W, 32, width of each entry
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- clr  in  1  single-cycle request to zero the whole array
- busy  out  1  clear sweep in progress
- wr_drop  out  1  one-cycle pulse: a write was rejected

## Operation

- Reset (rst_n low, asynchronous): every entry = 0, FSM = IDLE, sweep pointer = 0, busy = 0, wr_drop = 0; rdata therefore reads 0 on all ports.
- Write accepted when we=1, FSM=IDLE, and not (ZERO_REG=1 and waddr=0); entry updated at the rising edge.
- Read: rdata[i] = array[raddr[i]], combinational; with ZERO_REG=1, raddr[i]=0 always returns 0.
- FSM states:
  - IDLE: on clr=1 -> CLEAR, pointer loaded with 1 if ZERO_REG else 0.
  - CLEAR: writes 0 to array[pointer] each cycle, pointer increments; after writing DEPTH-1 -> IDLE.
- busy = (state == CLEAR), registered.
- Write requested while busy: dropped; wr_drop = 1 in the following cycle, for one cycle. A write to entry 0 with ZERO_REG=1 is silently ignored (no wr_drop).
- clr while busy: ignored (sweep not restarted). clr and we in the same IDLE cycle: write is performed at that edge, then the sweep starts on the next cycle and clears it.
- Reads during CLEAR return current contents (already-swept entries read 0).

## Timing

- Write latency: data visible in array one edge after we; see Configuration for same-cycle visibility.
- Read latency: 0 cycles (combinational from raddr).
- Clear duration: busy high DEPTH-1 cycles (ZERO_REG=1) or DEPTH cycles (ZERO_REG=0), starting the cycle after clr is sampled.
- wr_drop: registered, asserted exactly one cycle after the rejected we.
- rst_n asserted mid-sweep: immediate abort, all state as at reset; no pending clear after deassertion.

## Configuration

- REGFILE_BYPASS_EN defined: if an accepted write targets raddr[i] in the same cycle, rdata[i] = wdata (write-first forwarding); rejected writes and ignored entry-0 writes are never forwarded.
- Undefined: rdata[i] returns the pre-write array value until the next edge (read-first).

## Test plan

- Reset then read all ports at addresses 0..31 -> rdata = 0 everywhere, busy = 0, wr_drop = 0.
- Write 0xDEADBEEF to entry 5, next cycle raddr0=5, raddr1=0 -> rdata0 = 0xDEADBEEF, rdata1 = 0; write 0x1234 to entry 0 -> entry 0 still reads 0.
- Same-cycle write 0xA5A5A5A5 to entry 7 with raddr0=7 -> rdata0 = 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without.
- Fill entries 1..31 with index value, pulse clr -> busy high exactly 31 cycles, entry k reads 0 from cycle k after start, all 0 at end.
- we=1 to entry 3 with 0x55 during busy -> wr_drop pulses one cycle later, entry 3 = 0 after sweep.
- Drop rst_n at sweep cycle 10 with entries 20..31 still nonzero -> busy = 0 and all entries 0 immediately; after release, no further sweep.

Source files
------------

// File: rtl/reg_file_multiport.sv
// Multi-port register file: sync write, NUM_RD combinational reads, optional hard-zero entry 0, hardware clear sweep.
// Latency: write visible one edge later (same cycle with REGFILE_BYPASS_EN defined), reads 0 cycles; clear takes DEPTH-1/DEPTH cycles.
// Backpressure: none; writes arriving during a clear sweep are dropped and flagged on wr_drop one cycle later.
module reg_file_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_zero_hit;
    logic              w_wr_acc;
    logic              w_wr_rej;
    logic [ADDR_W-1:0] w_ptr_init;

    // Entry-0 writes under ZERO_REG are discarded silently, even mid-sweep.
    assign w_zero_hit = (ZERO_REG != 0) && (waddr == '0);
    assign w_wr_acc   = we && (r_state == S_IDLE)  && !w_zero_hit;
    assign w_wr_rej   = we && (r_state == S_CLEAR) && !w_zero_hit;
    assign w_ptr_init = (ZERO_REG != 0) ? ADDR_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_drop <= w_wr_rej;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        r_mem[waddr] <= wdata;
                    end
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_ptr_init;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_ptr] <= '0;
                    r_ptr        <= r_ptr + ADDR_W'(1);
                    if (r_ptr == {ADDR_W{1'b1}}) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign wr_drop = r_wr_drop;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_acc && (waddr == w_ra)) begin
                w_rd = wdata;
            end
`endif
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = w_rd;
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Self-checking bench for reg_file_multiport (default parameters, 2 read ports, entry 0 hard-zero).
module tb_reg_file_multiport;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        clr = 1'b0;
    logic        busy;
    logic        wr_drop;

    int errors = 0;
    int checks = 0;

    // Reference: array contents, sweep progress as "next entry to zero", last-cycle drop flag.
    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_next;
    bit          m_drop;

    reg_file_multiport dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .clr(clr), .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = 0;
        m_next = 0;
        m_drop = 0;
    endfunction

    function automatic logic [31:0] exp_rd(input int ra);
        logic [31:0] e;
        e = (ra == 0) ? 32'h0 : m_mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (we && !m_busy && waddr != 5'd0 && int'(waddr) == ra) e = wdata;
`endif
        return e;
    endfunction

    task automatic drive(input bit w, input int wa, input logic [31:0] wd, input bit c,
                         input int r0, input int r1);
        @(negedge clk);
        we    = w;
        waddr = 5'(wa);
        wdata = wd;
        clr   = c;
        raddr = {5'(r1), 5'(r0)};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_busy) begin
            m_drop = we && (waddr != 5'd0);
            m_mem[m_next] = '0;
            m_next++;
            if (m_next == 32) m_busy = 0;
        end else begin
            m_drop = 0;
            if (we && waddr != 5'd0) m_mem[waddr] = wdata;
            if (clr) begin
                m_busy = 1;
                m_next = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b wr_drop=%b, required 0/0", busy, wr_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 0, 32'h0, 1'b0, a, 31 - a);
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d: rdata=%h, required 0", a, rdata);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 1, 2);
        tick();
        drive(1'b0, 0, 32'h0, 1'b0, 5, 0);
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF || rdata[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL write_read: rdata0=%h rdata1=%h, required deadbeef/0", rdata[31:0], rdata[63:32]);
        end
        drive(1'b1, 0, 32'h1234, 1'b0, 0, 5);
        tick();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 5);
        checks++;
        if (rdata[31:0] !== 32'h0 || rdata[63:32] !== 32'hDEADBEEF || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: rdata0=%h rdata1=%h wr_drop=%b, required 0/deadbeef/0",
                     rdata[31:0], rdata[63:32], wr_drop);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] req;
`ifdef REGFILE_BYPASS_EN
        req = 32'hA5A5A5A5;
`else
        req = 32'h0;
`endif
        drive(1'b1, 7, 32'hA5A5A5A5, 1'b0, 7, 7);
        checks++;
        if (rdata[31:0] !== req || rdata[63:32] !== req) begin
            errors++;
            $display("FAIL same_cycle_read: rdata=%h, required both %h", rdata, req);
        end
        tick();
        drive(1'b0, 0, 32'h0, 1'b0, 7, 5);
        checks++;
        if (rdata[31:0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL after_write: rdata0=%h, required a5a5a5a5", rdata[31:0]);
        end
    endtask

    task automatic fill_index();
        for (int k = 1; k < 32; k++) begin
            drive(1'b1, k, 32'(k), 1'b0, 0, 0);
            tick();
        end
    endtask

    task automatic test_clear_sweep();
        int cnt;
        fill_index();
        drive(1'b0, 0, 32'h0, 1'b1, 9, 31);
        tick();
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            drive(1'b0, 0, 32'h0, 1'b0, cnt % 32, cnt - 1);
            checks++;
            if (rdata[31:0] !== exp_rd(cnt % 32) || rdata[63:32] !== 32'h0) begin
                errors++;
                $display("FAIL sweep_read cyc=%0d: rdata0=%h rdata1=%h, required %h/0",
                         cnt, rdata[31:0], rdata[63:32], exp_rd(cnt % 32));
            end
            tick();
        end
        checks++;
        if (cnt != 31) begin
            errors++;
            $display("FAIL sweep_len: busy cycles=%0d, required 31", cnt);
        end
        for (int a = 0; a < 32; a += 2) begin
            drive(1'b0, 0, 32'h0, 1'b0, a, a + 1);
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL sweep_done a=%0d: rdata=%h, required 0", a, rdata);
            end
        end
    endtask

    task automatic test_drop();
        int guard;
        drive(1'b1, 3, 32'h77, 1'b0, 0, 0);
        tick();
        drive(1'b0, 0, 32'h0, 1'b1, 0, 0);
        tick();
        repeat (4) begin
            drive(1'b0, 0, 32'h0, 1'b0, 0, 0);
            tick();
        end
        drive(1'b1, 3, 32'h55, 1'b0, 3, 0);
        tick();
        checks++;
        if (wr_drop !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: wr_drop=%b busy=%b, required 1/1", wr_drop, busy);
        end
        drive(1'b0, 0, 32'h0, 1'b1, 3, 0);
        tick();
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_width: wr_drop=%b, required 0", wr_drop);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            drive(1'b0, 0, 32'h0, 1'b0, 3, 4);
            tick();
            guard++;
        end
        checks++;
        if (busy !== 1'b0 || m_busy) begin
            errors++;
            $display("FAIL drop_sweep_end: busy=%b after %0d cycles, required 0 and no restart", busy, guard);
        end
        drive(1'b0, 0, 32'h0, 1'b0, 3, 4);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL drop_entry3: rdata=%h, required 0", rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 12, 32'hCAFEF00D, 1'b1, 12, 13);
        tick();
        drive(1'b0, 0, 32'h0, 1'b0, 12, 13);
        checks++;
        if (busy !== 1'b1 || rdata[31:0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL clr_we_same: busy=%b rdata0=%h, required 1/cafef00d", busy, rdata[31:0]);
        end
        for (int i = 0; i < 40 && m_busy; i++) begin
            drive(1'b0, 0, 32'h0, 1'b0, 12, 0);
            tick();
        end
        drive(1'b0, 0, 32'h0, 1'b0, 12, 13);
        checks++;
        if (busy !== 1'b0 || rdata[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL clr_we_cleared: busy=%b rdata0=%h, required 0/0", busy, rdata[31:0]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        fill_index();
        drive(1'b0, 0, 32'h0, 1'b1, 0, 0);
        tick();
        repeat (10) begin
            drive(1'b0, 0, 32'h0, 1'b0, 25, 31);
            tick();
        end
        checks++;
        if (busy !== 1'b1 || rdata[31:0] !== 32'd25) begin
            errors++;
            $display("FAIL pre_abort: busy=%b rdata0=%h, required 1/19", busy, rdata[31:0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: busy=%b wr_drop=%b, required 0/0", busy, wr_drop);
        end
        for (int a = 0; a < 32; a += 2) begin
            raddr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL abort_read a=%0d: rdata=%h, required 0", a, rdata);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            drive(1'b0, 0, 32'h0, 1'b0, 20, 31);
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_resume: busy=%b, required 0", busy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r0, r1;
            r0 = int'($urandom_range(31));
            r1 = int'($urandom_range(31));
            drive(1'($urandom_range(1)), int'($urandom_range(31)), $urandom,
                  ($urandom_range(99) < 3), r0, r1);
            checks++;
            if (rdata[31:0] !== exp_rd(r0) || rdata[63:32] !== exp_rd(r1)) begin
                errors++;
                $display("FAIL rand_read n=%0d: rdata=%h, required %h_%h", n, rdata, exp_rd(r1), exp_rd(r0));
            end
            tick();
            checks++;
            if (busy !== m_busy || wr_drop !== m_drop) begin
                errors++;
                $display("FAIL rand_flags n=%0d: busy=%b wr_drop=%b, required %b/%b", n, busy, wr_drop, m_busy, m_drop);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_sweep();
        test_drop();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
